// File: rtl/stage1.sv
// Decode/issue stage: holds one instruction, stalls on RAW hazards against stage2, flushes on mispredict.
// Latency: one register stage, zero bubbles when streaming; backpressure: rdy = !flush && (empty || handing off).
// Optional AXIS_CPU_STAGE1_STALL_CNT_EN adds a saturating hazard-cycle counter output stall_cnt.
module stage1 #(
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  instr_in,
    input  logic        prev_vld,
    output logic        rdy,
    output logic [7:0]  instr_out,
    output logic        vld,
    input  logic        next_rdy,
    input  logic        branch_mispredict,
    input  logic        stage2_writes_A,
    input  logic        stage2_writes_X,
    input  logic        PC_en,
    output logic [5:0]  icount,
    output logic [3:0]  regfile_rd_addr,
    output logic        B_sel,
    output logic        ALU_en
`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    // Opcode layout: class in [2:0], B source in [4], JMP sub-op in [7:5] (0 = JA), MISC [7]: 0 = TAX, 1 = TXA.
    localparam logic [2:0] CLS_ST   = 3'd2;
    localparam logic [2:0] CLS_STX  = 3'd3;
    localparam logic [2:0] CLS_ALU  = 3'd4;
    localparam logic [2:0] CLS_JMP  = 3'd5;
    localparam logic [2:0] CLS_MISC = 3'd7;

    // icount can never meaningfully exceed the code address span.
    localparam int         ICNT_MAX_I = (CODE_ADDR_WIDTH >= 6) ? 63 : (2 ** CODE_ADDR_WIDTH) - 1;
    localparam logic [5:0] ICNT_MAX   = ICNT_MAX_I[5:0];

    logic       r_vld;
    logic [7:0] r_instr;
    logic [5:0] r_icount;

    logic       w_is_alu;
    logic       w_is_jcond;
    logic       w_reads_a;
    logic       w_reads_x;
    logic       w_hazard;
    logic       w_vld;
    logic       w_handoff;
    logic       w_rdy;
    logic       w_accept;

    always_comb begin
        w_is_alu   = 1'b0;
        w_is_jcond = 1'b0;
        w_reads_a  = 1'b0;
        w_reads_x  = 1'b0;

        w_is_alu   = (r_instr[2:0] == CLS_ALU);
        w_is_jcond = (r_instr[2:0] == CLS_JMP) && (r_instr[7:5] != 3'd0);

        w_reads_a  = (r_instr[2:0] == CLS_ST) || w_is_alu || w_is_jcond ||
                     ((r_instr[2:0] == CLS_MISC) && !r_instr[7]);
        w_reads_x  = (r_instr[2:0] == CLS_STX) ||
                     ((r_instr[2:0] == CLS_MISC) && r_instr[7]) ||
                     ((w_is_alu || w_is_jcond) && r_instr[4]);
    end

    assign w_hazard  = r_vld && ((w_reads_a && stage2_writes_A) || (w_reads_x && stage2_writes_X));
    // rst_n gating keeps a held instruction from leaking out while reset is asserted.
    assign w_vld     = rst_n && r_vld && !w_hazard && !branch_mispredict;
    assign w_handoff = w_vld && next_rdy;
    assign w_rdy     = rst_n && !branch_mispredict && (!r_vld || w_handoff);
    assign w_accept  = prev_vld && w_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld    <= 1'b0;
            r_instr  <= 8'h00;
            r_icount <= 6'd0;
        end else begin
            if (branch_mispredict) begin
                r_vld <= 1'b0;
            end else if (w_accept) begin
                r_vld   <= 1'b1;
                r_instr <= instr_in;
            end else if (w_handoff) begin
                r_vld <= 1'b0;
            end

            if (w_accept) begin
                r_icount <= 6'd0;
            end else if (r_vld && PC_en && (r_icount != ICNT_MAX)) begin
                r_icount <= r_icount + 6'd1;
            end
        end
    end

`ifdef AXIS_CPU_STAGE1_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'h0000;
        end else if (w_hazard && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign rdy             = w_rdy;
    assign vld             = w_vld;
    assign instr_out       = r_instr;
    assign icount          = r_icount;
    assign regfile_rd_addr = r_instr[3:0];
    assign B_sel           = r_instr[4];
    assign ALU_en          = w_handoff && (w_is_alu || w_is_jcond);

endmodule

// File: doc/stage1.md
STAGE1 -- requirements
Module: stage1

Interface
REQ-001 SHALL have parameter CODE_ADDR_WIDTH, default 10, the width of the program counter and code address.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the synchronous, active-low reset.
REQ-004 SHALL have port instr_in, input, 8, the instruction byte from stage0.
REQ-005 SHALL have port prev_vld, input, 1, meaning stage0 holds a valid instr_in.
REQ-006 SHALL have port rdy, output, 1, meaning stage1 accepts instr_in this cycle.
REQ-007 SHALL have port instr_out, output, 8, the held instruction presented to stage2.
REQ-008 SHALL have port vld, output, 1, meaning instr_out is valid for stage2.
REQ-009 SHALL have port next_rdy, input, 1, the stage2 ready.
REQ-010 SHALL have port branch_mispredict, input, 1, the flush request from stage2.
REQ-011 SHALL have ports stage2_writes_A and stage2_writes_X, input, 1 each, the stage2 pending-write flags.
REQ-012 SHALL have port PC_en, input, 1, the PC advance pulse.
REQ-013 SHALL have port icount, output, 6, the count of PC advances since the held instruction was accepted.
REQ-014 SHALL have ports regfile_rd_addr (output, 4, equal to instr_out[3:0]), B_sel (output, 1, instr_out[4]: 1=X, 0=IMM) and ALU_en (output, 1, the issue pulse).

Function
REQ-015 SHALL hold one instruction in a register pair (vld_r, instr_r); instr_out SHALL equal instr_r.
REQ-016 SHALL set reads_A when the opcode class is ST, ALU, TAX, or JMP other than JA.
REQ-017 SHALL set reads_X when the opcode is STX or TXA, or is ALU/non-JA JMP with instr_r[4]=1.
REQ-018 SHALL compute hazard = vld_r && ((reads_A && stage2_writes_A) || (reads_X && stage2_writes_X)).
REQ-019 SHALL drive vld = vld_r && !hazard && !branch_mispredict.
REQ-020 SHALL define handoff as vld && next_rdy; ALU_en SHALL equal handoff && (opcode ALU or non-JA JMP).
REQ-021 SHALL drive rdy = !branch_mispredict && (!vld_r || handoff), combinationally.
REQ-022 SHALL load on accept (prev_vld && rdy): instr_r<=instr_in, vld_r<=1, icount<=0; handoff without accept SHALL clear vld_r.
REQ-023 SHALL, on branch_mispredict=1, clear vld_r next edge, ignore instr_in, suppress handoff, and give flush priority over accept/hold.
REQ-024 SHALL increment icount by 1 on each cycle with vld_r && PC_en && no accept, saturating at 63.
REQ-025 SHALL let accept override increment when both occur on the same edge.
REQ-026 SHALL, on a hazard cycle, hold instr_r and icount unchanged apart from the REQ-024 increment; stall latency SHALL equal hazard duration, with no extra cycle.
REQ-027 SHALL give zero-bubble throughput: back-to-back accept and handoff every cycle when there is no hazard and next_rdy=1.

Reset
REQ-028 SHALL, while rst_n=0 at an edge, set vld_r=0, instr_r=8'h00 and icount=0.
REQ-029 SHALL keep rdy=0 and ALU_en=0 during reset cycles.
REQ-030 SHALL discard an instruction held mid-operation on reset, with no handoff.

Configuration
REQ-031 SHALL, when AXIS_CPU_STAGE1_STALL_CNT_EN is defined, add output stall_cnt[15:0]: +1 each cycle with hazard=1, saturating at 16'hFFFF, cleared by reset only.
REQ-032 SHALL, when AXIS_CPU_STAGE1_STALL_CNT_EN is undefined, omit the stall_cnt port and counter entirely.

Verification
REQ-033 SHALL test streaming: 4 non-hazard instructions, prev_vld=next_rdy=1 -> vld=1 four consecutive cycles, instr_out in order, rdy stays 1.
REQ-034 SHALL test RAW hazard: held ALU instruction, stage2_writes_A=1 for 3 cycles -> vld=0 and rdy=0 3 cycles, then handoff with ALU_en=1 (stall_cnt=3 if enabled).
REQ-035 SHALL test flush: branch_mispredict=1 with vld_r=1 and prev_vld=1 -> vld=0, rdy=0 that cycle, vld_r=0 next cycle, instr_in dropped.
REQ-036 SHALL test icount: hold with next_rdy=0 and PC_en high 70 cycles -> icount reaches 63 and stays; a new accept -> icount=0.
REQ-037 SHALL test reset: rst_n=0 mid-hold -> next cycle vld=0, icount=0, instr_out=8'h00; rdy returns 1 after rst_n=1.
